// File: rtl/ras_ckpt_if.sv
// Interface bundling the fetch-side control, flush-checkpoint and status signals
// of the return address stack.
//   master : fetch/retire logic driving push/pop/flush and observing status
//   slave  : the stack itself (ras_ckpt)
// Signals: stall_i, push_i, pop_i, push_data_i, flush_i, flush_ptr_i, flush_cnt_i,
//          flush_tos_i (towards the stack); tos_data_o, tos_valid_o, ptr_o, cnt_o,
//          ovf_o, unf_o (from the stack).
interface ras_ckpt_if #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH) + 1
);
  logic              stall_i;
  logic              push_i;
  logic              pop_i;
  logic [DATA_W-1:0] push_data_i;
  logic              flush_i;
  logic [PTR_W-1:0]  flush_ptr_i;
  logic [CNT_W-1:0]  flush_cnt_i;
  logic [DATA_W-1:0] flush_tos_i;
  logic [DATA_W-1:0] tos_data_o;
  logic              tos_valid_o;
  logic [PTR_W-1:0]  ptr_o;
  logic [CNT_W-1:0]  cnt_o;
  logic              ovf_o;
  logic              unf_o;

  modport master (
    output stall_i, push_i, pop_i, push_data_i,
    output flush_i, flush_ptr_i, flush_cnt_i, flush_tos_i,
    input  tos_data_o, tos_valid_o, ptr_o, cnt_o, ovf_o, unf_o
  );

  modport slave (
    input  stall_i, push_i, pop_i, push_data_i,
    input  flush_i, flush_ptr_i, flush_cnt_i, flush_tos_i,
    output tos_data_o, tos_valid_o, ptr_o, cnt_o, ovf_o, unf_o
  );
endinterface

// File: rtl/ras_ckpt.sv
// Checkpoint-repairable return address stack for the fetch unit.
// Circular DEPTH x DATA_W stack with a registered top-of-stack copy, occupancy
// tracking and overflow/underflow pulses. A retire-stage flush restores pointer,
// occupancy and TOS from a checkpoint held in the branch ordering buffer.
// Ports:
//   clock    core clock
//   reset_n  asynchronous active-low reset
//   rif      ras_ckpt_if.slave: push/pop/stall controls, flush checkpoint inputs,
//            registered TOS/valid/ptr/cnt and 1-cycle ovf/unf pulses
module ras_ckpt #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic      clock,
  input  logic      reset_n,
  ras_ckpt_if.slave rif
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    OP_NONE,
    OP_POP,
    OP_PUSH,
    OP_REPL,
    OP_FLUSH
  } op_e;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tos_q, tos_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  ptr_dec;
  op_e               op;

  // Pointer width equals log2(DEPTH), so plain wrap-around is modulo DEPTH.
  assign ptr_inc = ptr_q + PTR_W'(1);
  assign ptr_dec = ptr_q - PTR_W'(1);

  // Flush ignores stall; push/pop are suppressed while the icache stalls.
  always_comb begin
    op = OP_NONE;
    if (rif.flush_i) begin
      op = OP_FLUSH;
    end else if (!rif.stall_i) begin
      unique case ({rif.push_i, rif.pop_i})
        2'b11:   op = OP_REPL;
        2'b10:   op = OP_PUSH;
        2'b01:   op = OP_POP;
        default: op = OP_NONE;
      endcase
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tos_d     = tos_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = rif.push_data_i;

    unique case (op)
      OP_FLUSH: begin
        ptr_d     = rif.flush_ptr_i;
        cnt_d     = rif.flush_cnt_i;
        tos_d     = rif.flush_tos_i;
        mem_we    = 1'b1;
        mem_waddr = rif.flush_ptr_i;
        mem_wdata = rif.flush_tos_i;
      end
      OP_REPL: begin
        // Call-return pair: overwrite the current top in place.
        tos_d  = rif.push_data_i;
        mem_we = 1'b1;
        if (cnt_q == '0) begin
          cnt_d = CNT_W'(1);
        end
      end
      OP_PUSH: begin
        ptr_d     = ptr_inc;
        tos_d     = rif.push_data_i;
        mem_we    = 1'b1;
        mem_waddr = ptr_inc;
        // When full, the write lands on the oldest slot and occupancy saturates.
        if (cnt_q == CNT_FULL) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OP_POP: begin
        if (cnt_q == '0) begin
          unf_d = 1'b1;
        end else begin
          ptr_d = ptr_dec;
          cnt_d = cnt_q - CNT_W'(1);
          tos_d = mem[ptr_dec];
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      tos_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      tos_q <= tos_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rif.tos_data_o  = tos_q;
  assign rif.tos_valid_o = (cnt_q != '0);
  assign rif.ptr_o       = ptr_q;
  assign rif.cnt_o       = cnt_q;
  assign rif.ovf_o       = ovf_q;
  assign rif.unf_o       = unf_q;

endmodule
